// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch path.
//   fetch_entry_t     : one queued (pc, instr) pair
//   FETCH_QUEUE_DEPTH : default depth for fetch_queue
package fetch_pkg;

    localparam int unsigned FETCH_XLEN        = 32;
    localparam int unsigned FETCH_QUEUE_DEPTH = 4;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the PC register / I-cache and decode.
// Fetch pushes one (pc, instr) pair per cycle on an I-cache hit; decode
// drains pairs in program order through valid/ready. A redirect (flush)
// empties the queue in one cycle.
//
// Optional feature macro: FETCH_QUEUE_BYPASS_EN
//   When defined, a pair pushed into an empty queue is presented to decode
//   in the same cycle and, if consumed, is never stored.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-low reset
//   flush       redirect, discard all entries at the next edge
//   push_valid  fetch presents a pair
//   push_pc     PC of the fetched instruction
//   push_instr  fetched instruction word
//   push_ready  queue can accept a pair (state only, never depends on pop)
//   pop_valid   head pair is available
//   pop_pc      PC of the head pair
//   pop_instr   instruction word of the head pair
//   pop_ready   decode consumes the head this cycle
//   count       occupied entries, 0..DEPTH
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = FETCH_QUEUE_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push_valid,
    input  logic [FETCH_XLEN-1:0] push_pc,
    input  logic [FETCH_XLEN-1:0] push_instr,
    output logic                  push_ready,
    output logic                  pop_valid,
    output logic [FETCH_XLEN-1:0] pop_pc,
    output logic [FETCH_XLEN-1:0] pop_instr,
    input  logic                  pop_ready,
    output logic [AW:0]           count
);

    localparam int unsigned CW = AW + 1;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic          full;
    logic          empty;
    logic          bypass;
    logic          store_push;
    logic          store_pop;

    // Status flags derived from the occupancy counter only
    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == CW'(0));
    assign push_ready = ~full;
    assign count      = count_q;

    assign push_entry = '{pc: push_pc, instr: push_instr};
    assign head_entry = mem_q[rd_ptr_q];

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue forwards the incoming pair; a pending flush suppresses it
    assign bypass     = empty & push_valid & ~flush;
    assign pop_valid  = ~empty | bypass;
    assign pop_pc     = bypass ? push_pc    : head_entry.pc;
    assign pop_instr  = bypass ? push_instr : head_entry.instr;
    // A bypassed pair taken by decode never lands in storage
    assign store_push = push_valid & push_ready & ~(bypass & pop_ready);
`else
    assign bypass     = 1'b0;
    assign pop_valid  = ~empty;
    assign pop_pc     = head_entry.pc;
    assign pop_instr  = head_entry.instr;
    assign store_push = push_valid & push_ready;
`endif

    // Only a stored entry can be popped from storage
    assign store_pop  = ~empty & pop_ready;

    // Next-state for pointers and occupancy; flush discards same-cycle push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (store_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (store_push && !store_pop) begin
                count_d = count_q + CW'(1);
            end else if (!store_push && store_pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Pointer and counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are never reset, only written on an accepted push
    always_ff @(posedge clk) begin
        if (reset && !flush && store_push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // Keeps the bypass term visible in both builds
    logic unused_bypass;
    assign unused_bypass = bypass;

endmodule : fetch_queue
